// File: rtl/scan_frame_engine_if.sv
// Host and scan-chain signal bundle for scan_frame_engine.
//   slave  : engine side (host request and scan_data_in in; controls and status out)
//   master : host/chain side (mirror image of slave)
// Host request  : active_select, in_data, mode, start, ws_cfg, half_period
// Host response : busy, out_valid, out_data, frame_cnt, sel_err
// Scan chain    : scan_clk_out, scan_data_out, scan_select, scan_latch_en, scan_data_in
interface scan_frame_engine_if #(
    parameter int unsigned NUM_IOS = 8,
    parameter int unsigned SEL_W   = 9,
    parameter int unsigned WS_W    = 8,
    parameter int unsigned HALF_W  = 4
);
    logic [SEL_W-1:0]   active_select;
    logic [NUM_IOS-1:0] in_data;
    logic               mode;
    logic               start;
    logic [WS_W-1:0]    ws_cfg;
    logic [HALF_W-1:0]  half_period;

    logic               busy;
    logic               out_valid;
    logic [NUM_IOS-1:0] out_data;
    logic [15:0]        frame_cnt;
    logic               sel_err;

    logic               scan_clk_out;
    logic               scan_data_out;
    logic               scan_select;
    logic               scan_latch_en;
    logic               scan_data_in;

    modport slave (
        input  active_select, in_data, mode, start, ws_cfg, half_period, scan_data_in,
        output busy, out_valid, out_data, frame_cnt, sel_err,
        output scan_clk_out, scan_data_out, scan_select, scan_latch_en
    );

    modport master (
        output active_select, in_data, mode, start, ws_cfg, half_period, scan_data_in,
        input  busy, out_valid, out_data, frame_cnt, sel_err,
        input  scan_clk_out, scan_data_out, scan_select, scan_latch_en
    );
endinterface

// File: rtl/scan_frame_engine.sv
// Internal scan-chain driver: shifts one NUM_IOS-bit word into the selected design of a
// daisy-chained design chain, latches it, parallel-loads all design outputs and shifts
// back just far enough to capture the selected design's output word.
// Ports:
//   clk      : sole clock, posedge
//   reset_n  : asynchronous active-low reset
//   bus      : scan_frame_engine_if.slave (host request/response and scan-chain controls)
module scan_frame_engine #(
    parameter int unsigned NUM_DESIGNS = 498,
    parameter int unsigned NUM_IOS     = 8,
    parameter int unsigned SEL_W       = 9,
    parameter int unsigned WS_W        = 8,
    parameter int unsigned HALF_W      = 4
) (
    input logic               clk,
    input logic               reset_n,
    scan_frame_engine_if.slave bus
);
    localparam int unsigned      STEP_W        = $clog2(NUM_DESIGNS * NUM_IOS + 1);
    localparam logic [SEL_W:0]   NumDesignsExt = NUM_DESIGNS[SEL_W:0];
    localparam logic [STEP_W-1:0] DesignsStep  = NUM_DESIGNS[STEP_W-1:0];
    localparam logic [STEP_W-1:0] IosStep      = NUM_IOS[STEP_W-1:0];

    typedef enum logic [3:0] {
        StIdle, StInLo, StInHi, StLatchWait, StLatch, StLoadPre,
        StLoadHi, StLoadPost, StOutLo, StOutHi, StCapWait, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_IOS-1:0] din_q, din_d;
    logic [WS_W-1:0]    ws_q, ws_d;
    logic [HALF_W-1:0]  half_q, half_d;
    logic [HALF_W-1:0]  phase_q, phase_d;
    logic [WS_W-1:0]    wait_q, wait_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [NUM_IOS-1:0] cap_q, cap_d;
    logic [NUM_IOS-1:0] out_data_q, out_data_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               sel_err_q, sel_err_d;
    logic               scan_clk_q, scan_clk_d;
    logic               scan_data_q, scan_data_d;
    logic               scan_sel_q, scan_sel_d;
    logic               scan_latch_q, scan_latch_d;

    logic               go, sel_ok, phase_end, wait_end, last_step;
    logic [STEP_W-1:0]  in_steps, out_steps;

    assign go        = bus.start | bus.mode;
    assign sel_ok    = {1'b0, bus.active_select} < NumDesignsExt;
    assign phase_end = (phase_q == half_q);
    assign wait_end  = (wait_q == ws_q);
    assign last_step = (step_q == STEP_W'(1));
    // The word must pass through sel designs ahead of the target; on the way back the
    // target sits behind NUM_DESIGNS-sel-1 designs plus its own word.
    assign in_steps  = (STEP_W'(bus.active_select) + STEP_W'(1)) * IosStep;
    assign out_steps = (DesignsStep - STEP_W'(sel_q)) * IosStep;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        din_d       = din_q;
        ws_d        = ws_q;
        half_d      = half_q;
        phase_d     = '0;
        wait_d      = '0;
        step_d      = step_q;
        cap_d       = cap_q;
        out_data_d  = out_data_q;
        frame_cnt_d = frame_cnt_q;
        sel_err_d   = sel_err_q;

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    if (sel_ok) begin
                        sel_d     = bus.active_select;
                        din_d     = bus.in_data;
                        ws_d      = bus.ws_cfg;
                        half_d    = bus.half_period;
                        step_d    = in_steps;
                        sel_err_d = 1'b0;
                        state_d   = StInLo;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            StInLo: begin
                if (phase_end) state_d = StInHi;
                else           phase_d = phase_q + 1'b1;
            end
            StInHi: begin
                if (phase_end) begin
                    // Zero fill makes the trailing sel*NUM_IOS steps drive 0.
                    din_d   = {din_q[NUM_IOS-2:0], 1'b0};
                    step_d  = step_q - 1'b1;
                    state_d = last_step ? StLatchWait : StInLo;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StLatchWait: begin
                if (wait_end) state_d = StLatch;
                else          wait_d  = wait_q + 1'b1;
            end
            StLatch: state_d = StLoadPre;
            StLoadPre: begin
                if (wait_end) state_d = StLoadHi;
                else          wait_d  = wait_q + 1'b1;
            end
            StLoadHi: begin
                if (phase_end) state_d = StLoadPost;
                else           phase_d = phase_q + 1'b1;
            end
            StLoadPost: begin
                if (wait_end) begin
                    step_d  = out_steps;
                    state_d = StOutLo;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StOutLo: begin
                if (phase_end) begin
                    // Tail has had the whole low phase to settle since the last rise.
                    cap_d   = {cap_q[NUM_IOS-2:0], bus.scan_data_in};
                    state_d = StOutHi;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StOutHi: begin
                if (phase_end) begin
                    step_d  = step_q - 1'b1;
                    state_d = last_step ? StCapWait : StOutLo;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StCapWait: begin
                if (wait_end) begin
                    out_data_d  = cap_q;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StDone;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Chain controls are registered decodes of the current state (one cycle lag).
    always_comb begin
        scan_clk_d   = (state_q == StInHi) || (state_q == StLoadHi) || (state_q == StOutHi);
        scan_sel_d   = (state_q == StLoadPre) || (state_q == StLoadHi) || (state_q == StLoadPost);
        scan_latch_d = (state_q == StLatch);
        scan_data_d  = (state_q == StInLo) ? din_q[NUM_IOS-1] : scan_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            din_q        <= '0;
            ws_q         <= '0;
            half_q       <= '0;
            phase_q      <= '0;
            wait_q       <= '0;
            step_q       <= '0;
            cap_q        <= '0;
            out_data_q   <= '0;
            frame_cnt_q  <= '0;
            sel_err_q    <= 1'b0;
            scan_clk_q   <= 1'b0;
            scan_data_q  <= 1'b0;
            scan_sel_q   <= 1'b0;
            scan_latch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            din_q        <= din_d;
            ws_q         <= ws_d;
            half_q       <= half_d;
            phase_q      <= phase_d;
            wait_q       <= wait_d;
            step_q       <= step_d;
            cap_q        <= cap_d;
            out_data_q   <= out_data_d;
            frame_cnt_q  <= frame_cnt_d;
            sel_err_q    <= sel_err_d;
            scan_clk_q   <= scan_clk_d;
            scan_data_q  <= scan_data_d;
            scan_sel_q   <= scan_sel_d;
            scan_latch_q <= scan_latch_d;
        end
    end

    assign bus.busy          = (state_q != StIdle);
    assign bus.out_valid     = (state_q == StDone);
    assign bus.out_data      = out_data_q;
    assign bus.frame_cnt     = frame_cnt_q;
    assign bus.sel_err       = sel_err_q;
    assign bus.scan_clk_out  = scan_clk_q;
    assign bus.scan_data_out = scan_data_q;
    assign bus.scan_select   = scan_sel_q;
    assign bus.scan_latch_en = scan_latch_q;
endmodule

// File: tb/tb_scan_frame_engine.sv
// Bench for scan_frame_engine with a 4-design x 8-bit chain model. Design k drives
// output word 0x10+k and latches whatever sits in its chain bits on scan_latch_en.
module tb_scan_frame_engine;
    localparam int ND   = 4;
    localparam int NIOS = 8;

    logic clk;
    logic reset_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    scan_frame_engine_if #(.NUM_IOS(NIOS), .SEL_W(9), .WS_W(8), .HALF_W(4)) bus ();

    scan_frame_engine #(
        .NUM_DESIGNS(ND), .NUM_IOS(NIOS), .SEL_W(9), .WS_W(8), .HALF_W(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- chain model ----------------
    logic [ND*NIOS-1:0] chain;
    logic [NIOS-1:0]    latched [ND];
    logic               sclk_prev;

    assign bus.scan_data_in = chain[ND*NIOS-1];

    initial begin
        chain     = '0;
        sclk_prev = 1'b0;
        for (int k = 0; k < ND; k++) latched[k] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.scan_clk_out && !sclk_prev) begin
                if (bus.scan_select) begin
                    for (int k = 0; k < ND; k++) chain[k*NIOS +: NIOS] = 8'h10 + 8'(k);
                end else begin
                    chain = {chain[ND*NIOS-2:0], bus.scan_data_out};
                end
            end
            if (bus.scan_latch_en) begin
                for (int k = 0; k < ND; k++) latched[k] = chain[k*NIOS +: NIOS];
            end
            sclk_prev = bus.scan_clk_out;
        end
    end

    // ---------------- frame-level reference model ----------------
    function automatic int latency(input int ws, input int half);
        int w;
        int h;
        w = ws + 1;
        h = half + 1;
        return 2 + 4 * w + h + 2 * h * NIOS * (ND + 1);
    endfunction

    logic            m_active  = 1'b0;
    int              m_done    = 0;
    logic [7:0]      m_data    = '0;
    logic [7:0]      m_out     = '0;
    logic [15:0]     m_frames  = '0;
    logic            m_sel_err = 1'b0;
    logic            exp_valid;

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            m_active  = 1'b0;
            m_out     = '0;
            m_frames  = '0;
            m_sel_err = 1'b0;
            check("rst_busy", 32'(bus.busy), 32'(0));
            check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        end else begin
            exp_valid = m_active && (cyc == m_done);
            if (exp_valid) begin
                m_out    = m_data;
                m_frames = m_frames + 16'd1;
            end
            check("busy", 32'(bus.busy), 32'(m_active));
            check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            check("out_data", 32'(bus.out_data), 32'(m_out));
            check("frame_cnt", 32'(bus.frame_cnt), 32'(m_frames));
            check("sel_err", 32'(bus.sel_err), 32'(m_sel_err));
            if (!m_active) begin
                check("idle_scan_clk", 32'(bus.scan_clk_out), 32'(0));
                check("idle_scan_select", 32'(bus.scan_select), 32'(0));
                check("idle_scan_latch", 32'(bus.scan_latch_en), 32'(0));
            end
            if (exp_valid) begin
                m_active = 1'b0;
            end else if (!m_active && (bus.start || bus.mode)) begin
                if (int'(bus.active_select) < ND) begin
                    m_active  = 1'b1;
                    m_done    = cyc + latency(int'(bus.ws_cfg), int'(bus.half_period));
                    m_data    = 8'h10 + 8'(bus.active_select);
                    m_sel_err = 1'b0;
                end else begin
                    m_sel_err = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_frame(input int sel, input logic [7:0] din, input int ws,
                               input int half, output int t0);
        @(posedge clk);
        #1;
        bus.active_select = 9'(sel);
        bus.in_data       = din;
        bus.ws_cfg        = 8'(ws);
        bus.half_period   = 4'(half);
        bus.mode          = 1'b0;
        bus.start         = 1'b1;
        t0                = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input int t0, input int budget, output int rel);
        int  n;
        logic found;
        n     = 0;
        found = 1'b0;
        rel   = -1;
        while (!found && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.out_valid === 1'b1) begin
                found = 1'b1;
                rel   = cyc - t0;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'(0));
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
        check({tag, "_out_data"}, 32'(bus.out_data), 32'(0));
        check({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'(0));
        check({tag, "_sel_err"}, 32'(bus.sel_err), 32'(0));
        check({tag, "_scan_clk"}, 32'(bus.scan_clk_out), 32'(0));
        check({tag, "_scan_data"}, 32'(bus.scan_data_out), 32'(0));
        check({tag, "_scan_select"}, 32'(bus.scan_select), 32'(0));
        check({tag, "_scan_latch"}, 32'(bus.scan_latch_en), 32'(0));
    endtask

    // ---------------- directed tests ----------------
    int         t0;
    int         t1;
    int         rel;
    int         guard;
    int         sw_sel [2] = '{0, 3};
    logic [7:0] sw_din [2] = '{8'h5A, 8'hC3};
    int         cont_at [3] = '{87, 175, 263};

    initial begin
        reset_n           = 1'b0;
        bus.active_select = '0;
        bus.in_data       = '0;
        bus.mode          = 1'b0;
        bus.start         = 1'b0;
        bus.ws_cfg        = '0;
        bus.half_period   = '0;
        #12;
        check_all_zero("reset");
        #10;
        reset_n = 1'b1;

        // Single shot, sel=2, in 0xA5, fastest timing.
        start_frame(2, 8'hA5, 0, 0, t0);
        wait_valid(t0, 400, rel);
        check("t1_valid_cycle", 32'(rel), 32'(87));
        check("t1_out_data", 32'(bus.out_data), 32'h12);
        check("t1_frame_cnt", 32'(bus.frame_cnt), 32'(1));
        check("t1_latched2", 32'(latched[2]), 32'hA5);
        check("t1_latched1", 32'(latched[1]), 32'h00);
        check("t1_latched0", 32'(latched[0]), 32'h00);

        // Select sweep at the chain ends with slower scan clock and longer waits.
        for (int i = 0; i < 2; i++) begin
            start_frame(sw_sel[i], sw_din[i], 3, 2, t0);
            wait_valid(t0, 600, rel);
            check("sweep_valid_cycle", 32'(rel), 32'(261));
            check("sweep_out_data", 32'(bus.out_data), 32'(8'h10 + 8'(sw_sel[i])));
            check("sweep_latched", 32'(latched[sw_sel[i]]), 32'(sw_din[i]));
        end
        check("sweep_frame_cnt", 32'(bus.frame_cnt), 32'(3));

        // Continuous mode, three back-to-back frames.
        @(posedge clk);
        #1;
        bus.active_select = 9'd1;
        bus.in_data       = 8'h77;
        bus.ws_cfg        = '0;
        bus.half_period   = '0;
        bus.mode          = 1'b1;
        t0                = cyc;
        for (int i = 0; i < 3; i++) begin
            wait_valid(t0, 400, rel);
            check("cont_valid_cycle", 32'(rel), 32'(cont_at[i]));
            check("cont_out_data", 32'(bus.out_data), 32'h11);
            if (i < 2) begin
                @(negedge clk);
                check("cont_gap_busy", 32'(bus.busy), 32'(0));
                @(negedge clk);
                check("cont_next_busy", 32'(bus.busy), 32'(1));
            end
        end
        @(posedge clk);
        #1;
        bus.mode = 1'b0;
        check("cont_frame_cnt", 32'(bus.frame_cnt), 32'(6));
        check("cont_latched1", 32'(latched[1]), 32'h77);

        // Out-of-range select, then a valid one.
        @(posedge clk);
        #1;
        bus.active_select = 9'd4;
        bus.start         = 1'b1;
        @(negedge clk);
        check("selerr_before", 32'(bus.sel_err), 32'(0));
        @(negedge clk);
        check("selerr_set", 32'(bus.sel_err), 32'(1));
        check("selerr_busy", 32'(bus.busy), 32'(0));
        @(negedge clk);
        check("selerr_hold", 32'(bus.sel_err), 32'(1));
        @(posedge clk);
        #1;
        bus.active_select = 9'd1;
        bus.in_data       = 8'h42;
        t1                = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("selerr_clear", 32'(bus.sel_err), 32'(0));
        check("selerr_go_busy", 32'(bus.busy), 32'(1));
        wait_valid(t1, 400, rel);
        check("selerr_valid_cycle", 32'(rel), 32'(87));
        check("selerr_out_data", 32'(bus.out_data), 32'h11);

        // Inputs disturbed mid-frame must not affect the frame in flight.
        start_frame(2, 8'h3C, 0, 0, t0);
        repeat (20) @(posedge clk);
        #1;
        bus.active_select = 9'd0;
        bus.in_data       = 8'hFF;
        bus.half_period   = 4'd5;
        bus.ws_cfg        = 8'd7;
        wait_valid(t0, 400, rel);
        check("mid_valid_cycle", 32'(rel), 32'(87));
        check("mid_out_data", 32'(bus.out_data), 32'h12);
        check("mid_latched2", 32'(latched[2]), 32'h3C);
        check("mid_latched1", 32'(latched[1]), 32'h00);
        check("mid_frame_cnt", 32'(bus.frame_cnt), 32'(8));

        // Reset while in OUT_HI (sel=1: IN occupies cycles 1..32, OUT_HI at 39, 41, ...).
        start_frame(1, 8'h81, 0, 0, t0);
        guard = 0;
        while (cyc != t0 + 41 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("rst_mid_busy", 32'(bus.busy), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        start_frame(1, 8'h81, 0, 0, t0);
        wait_valid(t0, 400, rel);
        check("post_rst_valid_cycle", 32'(rel), 32'(87));
        check("post_rst_out_data", 32'(bus.out_data), 32'h11);
        check("post_rst_frame_cnt", 32'(bus.frame_cnt), 32'(1));
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
